// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
// Bundles the feeder's control handshake, memory read port and array feed bus.
//   start           : request one feed pass (environment -> feeder)
//   busy, done      : pass in progress / one-cycle completion pulse
//   mem_read_enable : per-column read enables towards the operand memory
//   mem_read_elem   : 2-bit element index per column, column i at [2i+1:2i]
//   mem_data        : combinational read data from the memory, lane i at
//                     [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   feed_valid      : per-lane qualifier for feed_data
//   feed_data       : registered operand lanes presented to the systolic array
// Modport master is the feeder itself; slave is the surrounding system
// (memory plus whoever issues start and consumes the feed).
// -----------------------------------------------------------------------------
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [3:0]                mem_read_enable;
  logic [7:0]                mem_read_elem;
  logic [4*DATA_WIDTH-1:0]   mem_data;
  logic [3:0]                feed_valid;
  logic [4*DATA_WIDTH-1:0]   feed_data;

  modport master (
    input  start,
    input  mem_data,
    output busy,
    output done,
    output mem_read_enable,
    output mem_read_elem,
    output feed_valid,
    output feed_data
  );

  modport slave (
    output start,
    output mem_data,
    input  busy,
    input  done,
    input  mem_read_enable,
    input  mem_read_elem,
    input  feed_valid,
    input  feed_data
  );
endinterface

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Read sequencer between the 4x4 operand memory and the 4x4 systolic array.
// A start pulse in IDLE launches one pass: the four memory columns are read
// with a one-cycle diagonal skew per lane, the returned words are registered
// and presented to the array with per-lane valid flags, then done pulses.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : systolic_feeder_if.master (start/busy/done, memory read port,
//         array feed bus)
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_feeder_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_q;
  logic [2:0]                s_q;
  logic                      done_q;
  logic [3:0]                feed_valid_q;
  logic [4*DATA_WIDTH-1:0]   feed_data_q;

  logic [3:0]                rd_en;
  logic [7:0]                rd_elem;

  // Skewed read address: lane i is live for steps i..i+3 and reads element s-i.
  always_comb begin
    rd_en   = 4'b0000;
    rd_elem = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if ((state_q == FEED) && (s_q >= 3'(i)) && (s_q <= 3'(i + 3))) begin
        rd_en[i]         = 1'b1;
        rd_elem[2*i +: 2] = 2'(s_q - 3'(i));
      end else begin
        rd_en[i]         = 1'b0;
        rd_elem[2*i +: 2] = 2'b00;
      end
    end
  end

  // Pass sequencing plus one-cycle capture of the memory read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s_q          <= 3'd0;
      done_q       <= 1'b0;
      feed_valid_q <= 4'b0000;
      feed_data_q  <= {(4*DATA_WIDTH){1'b0}};
    end else begin
      feed_valid_q <= rd_en;
      // The memory already zeroes disabled columns; mask again so a
      // misbehaving or shared read bus can never leak into an idle lane.
      for (int i = 0; i < 4; i++) begin
        if (rd_en[i]) begin
          feed_data_q[DATA_WIDTH*i +: DATA_WIDTH] <= bus.mem_data[DATA_WIDTH*i +: DATA_WIDTH];
        end else begin
          feed_data_q[DATA_WIDTH*i +: DATA_WIDTH] <= {DATA_WIDTH{1'b0}};
        end
      end

      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= FEED;
            s_q     <= 3'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        FEED: begin
          if (s_q == 3'd6) begin
            state_q <= DRAIN;
          end else begin
            s_q <= s_q + 3'd1;
          end
        end
        DRAIN: begin
          // Last lane's final word is being presented now; done follows.
          state_q <= IDLE;
          s_q     <= 3'd0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          s_q     <= 3'd0;
        end
      endcase
    end
  end

  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = done_q;
  assign bus.mem_read_enable = rd_en;
  assign bus.mem_read_elem   = rd_elem;
  assign bus.feed_valid      = feed_valid_q;
  assign bus.feed_data       = feed_data_q;

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Read sequencer between the 4x4 operand `memory` block and the 4x4 systolic array. On a `start` pulse it walks the four memory lines (columns) with a diagonal skew. Lane `i` starts one cycle after lane `i-1`, so operands enter the array wavefront-aligned. It drives the memory's per-column read enables and element selects, registers the returned words, and presents them to the array with per-lane valid flags, followed by a `done` pulse.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of one operand element. Must match the memory block.

Ports:
- `clk`: in, 1 bit. Single clock. All state updates on the rising edge.
- `rst`: in, 1 bit. Reset, asynchronous and active-high.
- `start`: in, 1 bit. Request one feed pass. Sampled on the rising edge; acted on only in IDLE.
- `busy`: out, 1 bit. High while in FEED or DRAIN.
- `done`: out, 1 bit. One-cycle pulse after a pass completes.
- `mem_read_enable`: out, 4 bits. Goes to memory `read_enable`; bit `i` enables column `i`.
- `mem_read_elem`: out, 8 bits. Goes to memory `read_elem`; bits `[2i+1:2i]` give the element index for column `i`.
- `mem_data`: in, 4*DATA_WIDTH bits. From memory `data_out`; combinational read data.
- `feed_valid`: out, 4 bits. Bit `i` qualifies lane `i` of `feed_data`.
- `feed_data`: out, 4*DATA_WIDTH bits. Lane `i` occupies `[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]`.

## Operation
- State machine with three states: IDLE, FEED, DRAIN. A 3-bit step counter `s` runs 0..6 inside FEED.
- IDLE -> FEED on `start`=1. Set `s`=0.
- FEED, `s`<6: `s` increments by 1 each cycle. FEED, `s`=6: go to DRAIN.
- DRAIN -> IDLE unconditionally after one cycle. Assert `done` for the next cycle.
- Read address generation is combinational from state and `s`:
  - Lane `i` is active when the state is FEED and `i <= s <= i+3`.
  - For an active lane: `mem_read_enable[i]`=1 and element = `(s-i)` truncated to 2 bits.
  - For an inactive lane: enable=0 and element=2'b00.
  - Outside FEED, both ports are all-zero.
- Capture at every rising edge:
  - `feed_valid[i]` <= `mem_read_enable[i]`.
  - `feed_data` lane `i` <= the `mem_data` lane if its enable is set, else 0.
  - The memory already zeroes disabled columns; the feeder masks them again regardless.
- Result: `feed_data`/`feed_valid` are registered and lag the read address by exactly 1 cycle.
- Lane `i` delivers elements 0,1,2,3 of memory line `i`, in order, on 4 consecutive cycles.
- `busy` is decoded from the state register (state != IDLE), so it carries no combinational path from `start`.
- `start` while busy is ignored; it is not queued.
- `start` in the `done` cycle: the state is already IDLE, so the request is accepted.
- `start` held high continuously: a new pass begins on every return to IDLE.
- `rst` asserted at any time, including mid-pass: immediately forces IDLE, `s`=0, and all outputs to 0. No `done` is issued for an aborted pass.
- The feeder never writes memory. Writes to memory during a pass are the system's responsibility; data returned reflects memory contents at each read cycle.

## Timing
Cycle 0 is the cycle whose closing edge samples `start`=1 in IDLE.
- Cycles 1..7: FEED, step `s` = cycle-1. `busy`=1.
- Cycle 8: DRAIN, `busy`=1.
- Cycle 9: IDLE, `done`=1 and `busy`=0. The next pass can start with FEED in cycle 10. Back-to-back period is 9 cycles.
- `mem_read_enable[i]` is high in cycles `i+1`..`i+4`.
- `feed_valid[i]` is high in cycles `i+2`..`i+5`, carrying element `(cycle-i-2)`.
- Lane 0 therefore carries data in cycles 2..5 and lane 3 in cycles 5..8.
- The last valid data appears in DRAIN. `feed_valid` is 0 from cycle 9 onward.
- Reset values: `busy`=0, `done`=0, `mem_read_enable`=0, `mem_read_elem`=0, `feed_valid`=0, `feed_data`=0.

## Test plan
Use a behavioural memory model with `mem[l][e] = 16*l + e + 1`.
- Single pass:
  - Stimulus: `start` pulse in cycle 0.
  - Response: lane 0 `feed_data` = 0x01,0x02,0x03,0x04 in cycles 2..5, and lane 3 = 0x31..0x34 in cycles 5..8.
  - Response: `feed_valid` sequence = 0001, 0011, 0111, 1111, 1110, 1100, 1000, then 0000.
  - Response: `done`=1 only in cycle 9.
- Address check:
  - Response in cycle 4 (s=3): `mem_read_enable`=1111 and `mem_read_elem`=8'b00_01_10_11.
  - Response in cycle 7 (s=6): `mem_read_enable`=1000 and `mem_read_elem`=8'b11_00_00_00.
- Ignored start:
  - Stimulus: `start` pulsed again in cycles 3 and 6.
  - Response: identical output trace to the single pass, and exactly one `done`, in cycle 9.
- Continuous start:
  - Stimulus: `start` held high.
  - Response: `done` pulses in cycles 9 and 18. Second pass lane 0 data appears in cycles 11..14.
- Reset mid-pass:
  - Stimulus: `rst` asserted asynchronously in cycle 5, released in cycle 7.
  - Response: all outputs 0 immediately, no `done`, and a new `start` then yields a clean full pass.
- Masking:
  - Stimulus: drive garbage (0xFF) on disabled `mem_data` lanes.
  - Response: `feed_data` lanes with `feed_valid`=0 read 0x00.
